// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared PC-source selects, fetch state encoding and default vectors
// Common definitions for the multi-cycle MIPS fetch path.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational 4:1 next-PC selector
// Chooses among sequential, branch, jump and exception targets.
module next_pc_mux
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [1:0]  pc_source,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_address,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    case (pc_source)
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = branch_target;
      PCSRC_JUMP:   next_pc = jump_address;
      PCSRC_EXC:    next_pc = EXC_VECTOR;
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, instruction register and fetch handshake
// Holds PC/IR, sequences one imem request at a time, and loads the PC from next_pc_mux.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic [25:0] instr_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        alu_zero,
  input  logic [1:0]  pc_source,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_address,
  output logic        pc_misalign
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  imem_addr_q;
  logic [31:0]  ir_q;
  logic         ir_valid_q;
  logic         misalign_q;
  logic [31:0]  next_pc_d;
  logic         pc_en;

  assign pc_en    = pc_write | (pc_write_cond & alu_zero);
  assign pc_plus4 = pc_q + 32'd4;

  next_pc_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc_mux (
    .pc_source    (pc_source),
    .pc_plus4     (pc_plus4),
    .branch_target(branch_target),
    .jump_address (jump_address),
    .next_pc      (next_pc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      imem_addr_q <= RESET_PC;
      ir_q        <= 32'h0;
      ir_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      case (state_q)
        FETCH_IDLE: begin
          // Address captures the pre-update PC even if pc_en fires this edge.
          if (fetch_start) begin
            state_q     <= FETCH_REQ;
            imem_addr_q <= pc_q;
          end
        end
        FETCH_REQ: begin
          if (imem_ack) begin
            state_q    <= FETCH_IDLE;
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
      if (pc_en) begin
        pc_q <= next_pc_d;
        if (next_pc_d[1:0] != 2'b00) begin
          misalign_q <= 1'b1;
        end
      end
    end
  end

  assign fetch_busy  = (state_q == FETCH_REQ);
  assign imem_req    = fetch_busy;
  assign imem_addr   = imem_addr_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign instr_index = ir_q[25:0];
  assign pc          = pc_q;
  assign pc_misalign = misalign_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the multi-cycle MIPS core. It holds the PC and instruction register (IR), runs a request/acknowledge fetch against instruction memory, and exports IR[25:0] to the jump-address generator. It consumes that generator's 32-bit jump address back as one of the next-PC sources. The multi-cycle control FSM drives it; it sits between control, instruction memory, and the jump-address stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0180, target for pc_source = 2'b11.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  control requests an instruction fetch at the current PC.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, latched at request start.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse when ir has just been loaded.
- fetch_busy  out  1  high while a fetch is outstanding.
- instr_index  out  26  ir[25:0], feeds the jump-address generator.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- pc_write  in  1  unconditional PC load.
- pc_write_cond  in  1  conditional PC load, qualified by alu_zero.
- alu_zero  in  1  ALU zero flag.
- pc_source  in  2  next-PC select: 00 pc_plus4, 01 branch_target, 10 jump_address, 11 EXC_VECTOR.
- branch_target  in  32  branch target from ALUOut.
- jump_address  in  32  jump target from the jump-address generator.
- pc_misalign  out  1  sticky flag: a loaded PC had bits [1:0] ≠ 0.

## Operation
- The fetch FSM has two states, IDLE and REQ, encoded 1'b0 and 1'b1.
  - IDLE→REQ when fetch_start = 1. On the same edge, imem_addr ← pc, using the pre-update PC value.
  - REQ→IDLE when imem_ack = 1. On the same edge, ir ← imem_rdata and ir_valid ← 1 for exactly one cycle.
- In REQ: imem_req = 1 and imem_addr is held stable until ack. fetch_start is ignored.
- In IDLE: imem_ack is ignored.
- fetch_busy = (state == REQ). imem_req equals fetch_busy and is registered, not combinational from fetch_start.
- pc_en = pc_write | (pc_write_cond & alu_zero).
- When pc_en = 1, pc ← next_pc selected by pc_source. pc_en is honoured in either FSM state; imem_addr is unaffected because it is latched.
- If pc_en = 1 and next_pc[1:0] ≠ 0:
  - the PC still loads next_pc;
  - pc_misalign sets and stays set until reset.
- pc_plus4 is combinational from pc and wraps 32'hFFFF_FFFC→32'h0000_0000.
- ir holds its value until the next ack. instr_index always equals ir[25:0].

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - state = IDLE;
  - pc = RESET_PC;
  - imem_addr = RESET_PC;
  - ir = 0;
  - ir_valid = 0, imem_req = 0, fetch_busy = 0, pc_misalign = 0.
- Fetch latency: fetch_start sampled at edge 0 → imem_req high from edge 0.
  - Ack sampled at edge k ≥ 1 → ir valid and ir_valid high after edge k.
  - Minimum is 2 edges, start to IR.
- The PC update takes effect at the edge where pc_en is sampled. pc and pc_plus4 show the new value the following cycle.
- fetch_start and pc_en on the same edge: the fetch uses the old PC, and the PC advances.
- Reset asserted mid-fetch: imem_req drops immediately, and the pending ack is lost. After rst_n deasserts, the first edge sees IDLE.

## Structure
- Shared package mips_pkg holds:
  - PCSRC_SEQ/BRANCH/JUMP/EXC localparams (2'b00..2'b11);
  - the fetch state encoding;
  - the default RESET_PC and EXC_VECTOR values.
- Sub-module next_pc_mux: combinational 4:1 selector over pc_plus4, branch_target, jump_address and EXC_VECTOR, producing next_pc.
- The top level holds the FSM and the pc, ir and imem_addr registers, plus the misalign flag.

## Test plan
- Reset with default parameters: pc = 0, pc_plus4 = 4, all outputs at their reset values. Then fetch_start with ack 3 cycles later → imem_addr = 0 throughout REQ, ir = imem_rdata, ir_valid pulses exactly one cycle.
- ir = 32'h0800_0010, jump_address driven to 32'h0000_0040, pc_source = 10, pc_write → pc = 32'h40 next cycle; instr_index = 26'h000_0010.
- pc = 32'h100, branch_target = 32'h120, pc_source = 01, pc_write_cond = 1:
  - with alu_zero = 0 → pc stays 32'h100;
  - with alu_zero = 1 → pc = 32'h120.
- fetch_start and pc_write (seq) on the same edge at pc = 32'h8 → imem_addr = 32'h8 and pc = 32'hC. A second fetch_start during REQ is ignored, with a single ir_valid.
- pc = 32'hFFFF_FFFC with sequential pc_write → pc = 0. Then a jump to 32'h0000_0042 → pc = 32'h42 and pc_misalign stays 1 through a subsequent aligned load.
- rst_n pulsed low while in REQ → imem_req falls without waiting for a clock, ir = 0, pc = RESET_PC. An ack arriving after reset releases produces no ir_valid.
